mem_arbiter: RTL and testbench

Shares the single downstream memory bus between the instruction-fetch port and the data (load/store) port of the pipelined core. Grants one outstanding transaction at a time, with data requests prioritised and a burst limit so fetch cannot starve. Sits between the fetch/memory pipeline stages and the bus bridge.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_arb_pick.sv | 18 +
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared memory-pipeline types: arbiter state, grant owner and the downstream
// bus request record that the bus bridge also consumes.
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 64;
   localparam int ARB_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } arb_state_t;

   typedef enum logic {
      GNT_I,
      GNT_D
   } arb_gnt_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0]   addr;
      logic                    write;
      logic [ARB_DATA_W-1:0]   wdata;
      logic [ARB_DATA_W/8-1:0] strobe;
   } bus_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the bus bridge.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
);
   // Requests hold valid and all fields until their one-cycle resp_valid pulse;
   // bus_valid holds with stable fields until a one-cycle bus_ok.
   logic                  i_req_valid;
   logic [ADDR_W-1:0]     i_req_addr;
   logic                  i_resp_valid;
   logic [DATA_W-1:0]     i_resp_data;

   logic                  d_req_valid;
   logic [ADDR_W-1:0]     d_req_addr;
   logic                  d_req_write;
   logic [DATA_W-1:0]     d_req_wdata;
   logic [DATA_W/8-1:0]   d_req_strobe;
   logic                  d_resp_valid;
   logic [DATA_W-1:0]     d_resp_data;

   logic                  bus_valid;
   logic [ADDR_W-1:0]     bus_addr;
   logic                  bus_write;
   logic [DATA_W-1:0]     bus_wdata;
   logic [DATA_W/8-1:0]   bus_strobe;
   logic                  bus_ok;
   logic [DATA_W-1:0]     bus_data;

   modport slave (
      input  i_req_valid, i_req_addr,
      output i_resp_valid, i_resp_data,
      input  d_req_valid, d_req_addr, d_req_write, d_req_wdata, d_req_strobe,
      output d_resp_valid, d_resp_data,
      output bus_valid, bus_addr, bus_write, bus_wdata, bus_strobe,
      input  bus_ok, bus_data
   );

   modport master (
      output i_req_valid, i_req_addr,
      input  i_resp_valid, i_resp_data,
      output d_req_valid, d_req_addr, d_req_write, d_req_wdata, d_req_strobe,
      input  d_resp_valid, d_resp_data,
      input  bus_valid, bus_addr, bus_write, bus_wdata, bus_strobe,
      output bus_ok, bus_data
   );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Grant selection: data wins unless fetch is waiting and the data burst is used up.
module arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic     i_valid,
   input  logic     d_valid,
   input  logic     burst_full,
   output arb_gnt_t gnt
);

   always_comb begin
      gnt = GNT_I;
      if (d_valid && !(i_valid && burst_full)) begin
         gnt = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing the memory bus between fetch and data ports,
// with data priority bounded by a burst limit so fetch cannot starve.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int  ADDR_W      = ARB_ADDR_W,
   parameter int  DATA_W      = ARB_DATA_W,
   parameter int  MAX_D_BURST = 4,
   localparam int CNT_W       = $clog2(MAX_D_BURST + 1)
) (
   input  logic             clk,
   input  logic             reset,
   mem_arbiter_if.slave     arb_if,
   output arb_state_t       state_o,
   output arb_gnt_t         gnt_o,
   output logic [CNT_W-1:0] burst_cnt_o
);

   arb_state_t          state_q, state_d;
   arb_gnt_t            gnt_q, gnt_d;
   logic [CNT_W-1:0]    burst_q, burst_d;
   bus_req_t            bus_q, bus_d;
   logic                bus_valid_q, bus_valid_d;
   logic [DATA_W-1:0]   i_data_q, i_data_d;
   logic [DATA_W-1:0]   d_data_q, d_data_d;

   arb_gnt_t            pick_gnt;
   logic                burst_full;
   logic                any_req;
   logic [ADDR_W-1:0]   win_addr;
   logic                win_write;
   logic [DATA_W-1:0]   win_wdata;
   logic [DATA_W/8-1:0] win_strobe;

   assign burst_full = (burst_q == CNT_W'(MAX_D_BURST));
   assign any_req    = arb_if.i_req_valid || arb_if.d_req_valid;

   arb_pick u_pick (
      .i_valid    (arb_if.i_req_valid),
      .d_valid    (arb_if.d_req_valid),
      .burst_full (burst_full),
      .gnt        (pick_gnt)
   );

   // Fetch requests are always reads with no byte lanes enabled.
   always_comb begin
      win_addr   = arb_if.i_req_addr;
      win_write  = 1'b0;
      win_wdata  = '0;
      win_strobe = '0;
      if (pick_gnt == GNT_D) begin
         win_addr   = arb_if.d_req_addr;
         win_write  = arb_if.d_req_write;
         win_wdata  = arb_if.d_req_wdata;
         win_strobe = arb_if.d_req_strobe;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      burst_d     = burst_q;
      bus_d       = bus_q;
      bus_valid_d = bus_valid_q;
      i_data_d    = i_data_q;
      d_data_d    = d_data_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d       = pick_gnt;
               bus_d       = '{addr: win_addr, write: win_write, wdata: win_wdata, strobe: win_strobe};
               bus_valid_d = 1'b1;
               state_d     = BUSY;
               // Only data grants that make fetch wait count toward the burst.
               if (pick_gnt == GNT_D && arb_if.i_req_valid) begin
                  if (!burst_full) begin
                     burst_d = burst_q + CNT_W'(1);
                  end
               end else begin
                  burst_d = '0;
               end
            end
         end
         BUSY: begin
            if (arb_if.bus_ok) begin
               if (gnt_q == GNT_D) begin
                  d_data_d = arb_if.bus_data;
               end else begin
                  i_data_d = arb_if.bus_data;
               end
               bus_valid_d = 1'b0;
               state_d     = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= GNT_I;
         burst_q     <= '0;
         bus_q       <= '0;
         bus_valid_q <= 1'b0;
         i_data_q    <= '0;
         d_data_q    <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         burst_q     <= burst_d;
         bus_q       <= bus_d;
         bus_valid_q <= bus_valid_d;
         i_data_q    <= i_data_d;
         d_data_q    <= d_data_d;
      end
   end

   assign arb_if.bus_valid    = bus_valid_q;
   assign arb_if.bus_addr     = bus_q.addr;
   assign arb_if.bus_write    = bus_q.write;
   assign arb_if.bus_wdata    = bus_q.wdata;
   assign arb_if.bus_strobe   = bus_q.strobe;

   assign arb_if.i_resp_valid = (state_q == RESP) && (gnt_q == GNT_I);
   assign arb_if.d_resp_valid = (state_q == RESP) && (gnt_q == GNT_D);
   assign arb_if.i_resp_data  = i_data_q;
   assign arb_if.d_resp_data  = d_data_q;

   assign state_o     = state_q;
   assign gnt_o       = gnt_q;
   assign burst_cnt_o = burst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario with inline checks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   arb_state_t state_o;
   arb_gnt_t   gnt_o;
   logic [2:0] burst_cnt_o;

   int checks = 0;
   int errors = 0;
   int i_pulses = 0;
   int d_pulses = 0;
   logic bus_valid_prev = 1'b0;
   logic [0:0] got_q[$];
   logic [0:0] exp_q[$];

   mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) arb_if ();

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_D_BURST(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .arb_if      (arb_if),
      .state_o     (state_o),
      .gnt_o       (gnt_o),
      .burst_cnt_o (burst_cnt_o)
   );

   always #5 clk = ~clk;

   // Response pulse counters and grant log, sampled on the inactive edge.
   always @(negedge clk) begin
      if (arb_if.i_resp_valid === 1'b1) i_pulses++;
      if (arb_if.d_resp_valid === 1'b1) d_pulses++;
      if (arb_if.bus_valid === 1'b1 && bus_valid_prev !== 1'b1) got_q.push_back(gnt_o);
      bus_valid_prev = arb_if.bus_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Waits for bus_valid, inserts wait states, then completes with one bus_ok.
   task automatic serve(input int waits, input logic [63:0] rdata);
      int n = 0;
      while (arb_if.bus_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (arb_if.bus_valid !== 1'b1) begin
         errors++;
         $display("FAIL serve_timeout: bus_valid=%b after %0d cycles, required 1", arb_if.bus_valid, n);
         return;
      end
      repeat (waits) tick();
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = rdata;
      tick();
      arb_if.bus_ok   = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (state_o !== IDLE || gnt_o !== GNT_I || burst_cnt_o !== 3'd0) begin
         errors++;
         $display("FAIL reset_regs: state=%0d gnt=%0d burst=%0d, required 0 0 0", state_o, gnt_o, burst_cnt_o);
      end
      checks++;
      if (arb_if.bus_valid !== 1'b0 || arb_if.bus_addr !== 64'h0 || arb_if.bus_write !== 1'b0 ||
          arb_if.bus_wdata !== 64'h0 || arb_if.bus_strobe !== 8'h0) begin
         errors++;
         $display("FAIL reset_bus: valid=%b addr=%h write=%b wdata=%h strobe=%h, required all 0",
                  arb_if.bus_valid, arb_if.bus_addr, arb_if.bus_write, arb_if.bus_wdata, arb_if.bus_strobe);
      end
      checks++;
      if (arb_if.i_resp_valid !== 1'b0 || arb_if.d_resp_valid !== 1'b0 ||
          arb_if.i_resp_data !== 64'h0 || arb_if.d_resp_data !== 64'h0) begin
         errors++;
         $display("FAIL reset_resp: iv=%b dv=%b idata=%h ddata=%h, required all 0",
                  arb_if.i_resp_valid, arb_if.d_resp_valid, arb_if.i_resp_data, arb_if.d_resp_data);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (state_o !== IDLE || arb_if.bus_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_noreq: state=%0d bus_valid=%b, required IDLE 0", state_o, arb_if.bus_valid);
      end
   endtask

   task automatic test_single_fetch;
      int i0 = i_pulses;
      int d0 = d_pulses;
      arb_if.i_req_addr  = 64'h8000_0000;
      arb_if.i_req_valid = 1'b1;
      tick();
      checks++;
      if (arb_if.bus_valid !== 1'b1 || arb_if.bus_addr !== 64'h8000_0000 || arb_if.bus_write !== 1'b0 ||
          arb_if.bus_strobe !== 8'h0 || gnt_o !== GNT_I) begin
         errors++;
         $display("FAIL fetch_issue: valid=%b addr=%h write=%b strobe=%h gnt=%0d, required 1 80000000 0 00 0",
                  arb_if.bus_valid, arb_if.bus_addr, arb_if.bus_write, arb_if.bus_strobe, gnt_o);
      end
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = 64'h13;
      tick();
      arb_if.bus_ok   = 1'b0;
      checks++;
      if (arb_if.i_resp_valid !== 1'b1 || arb_if.i_resp_data !== 64'h13 ||
          arb_if.d_resp_valid !== 1'b0 || arb_if.bus_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_resp: iv=%b idata=%h dv=%b bus_valid=%b, required 1 13 0 0",
                  arb_if.i_resp_valid, arb_if.i_resp_data, arb_if.d_resp_valid, arb_if.bus_valid);
      end
      arb_if.i_req_valid = 1'b0;
      tick();
      checks++;
      if (state_o !== IDLE || arb_if.i_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL fetch_back_idle: state=%0d iv=%b, required IDLE 0", state_o, arb_if.i_resp_valid);
      end
      tick();
      checks++;
      if (i_pulses - i0 !== 1 || d_pulses - d0 !== 0) begin
         errors++;
         $display("FAIL fetch_pulse_count: i=%0d d=%0d, required 1 0", i_pulses - i0, d_pulses - d0);
      end
   endtask

   task automatic test_simultaneous;
      arb_if.i_req_addr   = 64'h4000;
      arb_if.i_req_valid  = 1'b1;
      arb_if.d_req_addr   = 64'h8000_1000;
      arb_if.d_req_write  = 1'b1;
      arb_if.d_req_wdata  = 64'hDEAD_BEEF;
      arb_if.d_req_strobe = 8'hFF;
      arb_if.d_req_valid  = 1'b1;
      tick();
      checks++;
      if (gnt_o !== GNT_D || arb_if.bus_addr !== 64'h8000_1000 || arb_if.bus_write !== 1'b1 ||
          arb_if.bus_wdata !== 64'hDEAD_BEEF || arb_if.bus_strobe !== 8'hFF || arb_if.bus_valid !== 1'b1) begin
         errors++;
         $display("FAIL sim_store_first: gnt=%0d addr=%h write=%b wdata=%h strobe=%h valid=%b, required 1 80001000 1 deadbeef ff 1",
                  gnt_o, arb_if.bus_addr, arb_if.bus_write, arb_if.bus_wdata, arb_if.bus_strobe, arb_if.bus_valid);
      end
      checks++;
      if (burst_cnt_o !== 3'd1) begin
         errors++;
         $display("FAIL sim_burst_inc: burst=%0d, required 1", burst_cnt_o);
      end
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = 64'h0;
      tick();
      arb_if.bus_ok   = 1'b0;
      checks++;
      if (arb_if.d_resp_valid !== 1'b1 || arb_if.i_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL sim_store_resp: dv=%b iv=%b, required 1 0", arb_if.d_resp_valid, arb_if.i_resp_valid);
      end
      arb_if.d_req_valid = 1'b0;
      tick();
      checks++;
      if (state_o !== IDLE || arb_if.bus_valid !== 1'b0) begin
         errors++;
         $display("FAIL sim_resp_to_idle: state=%0d bus_valid=%b, required IDLE 0", state_o, arb_if.bus_valid);
      end
      tick();
      checks++;
      if (gnt_o !== GNT_I || arb_if.bus_valid !== 1'b1 || arb_if.bus_addr !== 64'h4000 || burst_cnt_o !== 3'd0) begin
         errors++;
         $display("FAIL sim_fetch_second: gnt=%0d valid=%b addr=%h burst=%0d, required 0 1 4000 0",
                  gnt_o, arb_if.bus_valid, arb_if.bus_addr, burst_cnt_o);
      end
      serve(0, 64'h44);
      checks++;
      if (arb_if.i_resp_valid !== 1'b1 || arb_if.i_resp_data !== 64'h44) begin
         errors++;
         $display("FAIL sim_fetch_resp: iv=%b idata=%h, required 1 44", arb_if.i_resp_valid, arb_if.i_resp_data);
      end
      arb_if.i_req_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back;
      int d_sent = 0;
      int exp_burst[7] = '{1, 2, 3, 4, 0, 0, 0};
      logic [63:0] rdata;
      logic order_ok;
      got_q.delete();
      exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      arb_if.i_req_addr   = 64'h5000;
      arb_if.i_req_valid  = 1'b1;
      arb_if.d_req_addr   = 64'h100;
      arb_if.d_req_write  = 1'b0;
      arb_if.d_req_wdata  = 64'h0;
      arb_if.d_req_strobe = 8'h0;
      arb_if.d_req_valid  = 1'b1;
      for (int k = 0; k < 7; k++) begin
         rdata = 64'hA000 + 64'(k);
         serve(0, rdata);
         checks++;
         if (burst_cnt_o !== 3'(exp_burst[k])) begin
            errors++;
            $display("FAIL b2b_burst_cnt[%0d]: burst=%0d, required %0d", k, burst_cnt_o, exp_burst[k]);
         end
         if (arb_if.d_resp_valid === 1'b1) begin
            checks++;
            if (arb_if.d_resp_data !== rdata) begin
               errors++;
               $display("FAIL b2b_d_data[%0d]: data=%h, required %h", k, arb_if.d_resp_data, rdata);
            end
            d_sent++;
            if (d_sent < 6) arb_if.d_req_addr = 64'h100 + 64'(8 * d_sent);
            else arb_if.d_req_valid = 1'b0;
         end
         if (arb_if.i_resp_valid === 1'b1) begin
            checks++;
            if (arb_if.i_resp_data !== rdata) begin
               errors++;
               $display("FAIL b2b_i_data[%0d]: data=%h, required %h", k, arb_if.i_resp_data, rdata);
            end
            arb_if.i_req_valid = 1'b0;
         end
         tick();
      end
      order_ok = (got_q.size() == exp_q.size());
      if (order_ok) begin
         for (int k = 0; k < exp_q.size(); k++) if (got_q[k] !== exp_q[k]) order_ok = 1'b0;
      end
      checks++;
      if (!order_ok || d_sent != 6) begin
         errors++;
         $display("FAIL b2b_grant_order: got %p (%0d data done), required %p (6 data done)", got_q, d_sent, exp_q);
      end
   endtask

   task automatic test_wait_states;
      int d0;
      logic stable = 1'b1;
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = 64'hBAD;
      tick();
      arb_if.bus_ok   = 1'b0;
      checks++;
      if (state_o !== IDLE || arb_if.bus_valid !== 1'b0 || arb_if.d_resp_valid !== 1'b0 ||
          arb_if.i_resp_valid !== 1'b0 || arb_if.d_resp_data !== 64'hA006) begin
         errors++;
         $display("FAIL wait_ok_in_idle: state=%0d bv=%b dv=%b iv=%b ddata=%h, required IDLE 0 0 0 a006",
                  state_o, arb_if.bus_valid, arb_if.d_resp_valid, arb_if.i_resp_valid, arb_if.d_resp_data);
      end
      d0 = d_pulses;
      arb_if.d_req_addr  = 64'h2000;
      arb_if.d_req_write = 1'b0;
      arb_if.d_req_valid = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         if (arb_if.bus_valid !== 1'b1 || arb_if.bus_addr !== 64'h2000 || arb_if.bus_write !== 1'b0 ||
             state_o !== BUSY || arb_if.d_resp_valid !== 1'b0) stable = 1'b0;
         tick();
      end
      checks++;
      if (!stable || arb_if.bus_valid !== 1'b1 || arb_if.bus_addr !== 64'h2000) begin
         errors++;
         $display("FAIL wait_bus_stable: stable=%b valid=%b addr=%h, required 1 1 2000",
                  stable, arb_if.bus_valid, arb_if.bus_addr);
      end
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = 64'h55;
      tick();
      arb_if.bus_ok   = 1'b0;
      checks++;
      if (arb_if.d_resp_valid !== 1'b1 || arb_if.d_resp_data !== 64'h55) begin
         errors++;
         $display("FAIL wait_resp: dv=%b data=%h, required 1 55", arb_if.d_resp_valid, arb_if.d_resp_data);
      end
      arb_if.d_req_valid = 1'b0;
      tick();
      checks++;
      if (d_pulses - d0 !== 1 || state_o !== IDLE) begin
         errors++;
         $display("FAIL wait_pulse_count: pulses=%0d state=%0d, required 1 IDLE", d_pulses - d0, state_o);
      end
   endtask

   task automatic test_reset_busy;
      int i0 = i_pulses;
      arb_if.i_req_addr  = 64'h3000;
      arb_if.i_req_valid = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (state_o !== IDLE || arb_if.bus_valid !== 1'b0 || arb_if.i_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_abort: state=%0d bv=%b iv=%b, required IDLE 0 0",
                  state_o, arb_if.bus_valid, arb_if.i_resp_valid);
      end
      reset = 1'b0;
      serve(0, 64'h77);
      checks++;
      if (arb_if.i_resp_valid !== 1'b1 || arb_if.i_resp_data !== 64'h77) begin
         errors++;
         $display("FAIL rst_busy_recover: iv=%b data=%h, required 1 77", arb_if.i_resp_valid, arb_if.i_resp_data);
      end
      arb_if.i_req_valid = 1'b0;
      tick();
      checks++;
      if (i_pulses - i0 !== 1) begin
         errors++;
         $display("FAIL rst_busy_pulses: pulses=%0d, required 1", i_pulses - i0);
      end
   endtask

   task automatic test_drop_valid;
      int d0 = d_pulses;
      arb_if.d_req_addr   = 64'h6000;
      arb_if.d_req_write  = 1'b1;
      arb_if.d_req_wdata  = 64'h1234;
      arb_if.d_req_strobe = 8'h0F;
      arb_if.d_req_valid  = 1'b1;
      tick();
      arb_if.d_req_valid  = 1'b0;
      arb_if.d_req_addr   = 64'hFFFF;
      arb_if.d_req_write  = 1'b0;
      arb_if.d_req_wdata  = 64'h0;
      tick();
      checks++;
      if (arb_if.bus_valid !== 1'b1 || arb_if.bus_addr !== 64'h6000 || arb_if.bus_write !== 1'b1 ||
          arb_if.bus_wdata !== 64'h1234 || arb_if.bus_strobe !== 8'h0F) begin
         errors++;
         $display("FAIL drop_latched: valid=%b addr=%h write=%b wdata=%h strobe=%h, required 1 6000 1 1234 0f",
                  arb_if.bus_valid, arb_if.bus_addr, arb_if.bus_write, arb_if.bus_wdata, arb_if.bus_strobe);
      end
      arb_if.bus_ok   = 1'b1;
      arb_if.bus_data = 64'h0;
      tick();
      arb_if.bus_ok   = 1'b0;
      checks++;
      if (arb_if.d_resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL drop_resp: dv=%b, required 1", arb_if.d_resp_valid);
      end
      tick();
      tick();
      checks++;
      if (d_pulses - d0 !== 1 || state_o !== IDLE || arb_if.bus_valid !== 1'b0) begin
         errors++;
         $display("FAIL drop_once: pulses=%0d state=%0d bv=%b, required 1 IDLE 0",
                  d_pulses - d0, state_o, arb_if.bus_valid);
      end
   endtask

   initial begin
      reset               = 1'b1;
      arb_if.i_req_valid  = 1'b0;
      arb_if.i_req_addr   = '0;
      arb_if.d_req_valid  = 1'b0;
      arb_if.d_req_addr   = '0;
      arb_if.d_req_write  = 1'b0;
      arb_if.d_req_wdata  = '0;
      arb_if.d_req_strobe = '0;
      arb_if.bus_ok       = 1'b0;
      arb_if.bus_data     = '0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_back_to_back();
      test_wait_states();
      test_reset_busy();
      test_drop_valid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
